// File: rtl/alu_sequencer_pkg.sv
// Shared ALU constants: operand/address widths, opcodes, register-file
// addresses, sequencer FSM states and the latched request packet type.
package alu_sequencer_pkg;

   localparam int OPERAND_WIDTH    = 16;
   localparam int INST_ADDR_LENGTH = 2;

   typedef logic [OPERAND_WIDTH-1:0]    operand_t;
   typedef logic [INST_ADDR_LENGTH-1:0] alu_addr_t;

   // ALU opcodes; any other value is rejected by the ALU with error=1
   localparam operand_t OP_ADD  = 16'd0;
   localparam operand_t OP_SUB  = 16'd1;
   localparam operand_t OP_MULT = 16'd2;
   localparam operand_t OP_DIV  = 16'd3;

   // ALU register-file addresses
   localparam alu_addr_t ALU_ADDR_OP = 2'd0;
   localparam alu_addr_t ALU_ADDR_A  = 2'd1;
   localparam alu_addr_t ALU_ADDR_B  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_A    = 3'd1,
      ST_WR_B    = 3'd2,
      ST_WR_OP   = 3'd3,
      ST_SETTLE  = 3'd4,
      ST_MSETTLE = 3'd5,
      ST_OUT     = 3'd6
   } seq_state_e;

   typedef struct packed {
      operand_t op;
      operand_t a;
      operand_t b;
   } seq_pkt_t;

   // The multiplier output is registered inside the ALU, so a MULT
   // needs one extra settle cycle before its result can be captured.
   function automatic logic needs_mult_settle(input operand_t op);
      return op == OP_MULT;
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Feeds one request packet at a time into the ALU register file
// (A, then B, then opcode) and presents the captured result/flags.
//
// Ports:
//   clk, rstN             clock, async active-low reset
//   s_valid/s_ready       request handshake; s_opcode/s_opA/s_opB payload
//   alu_writeEn/Address   ALU register-file write port; alu_inst = data
//   alu_result, alu_*     ALU result and flags (error/zero/carry/overflow)
//   m_valid/m_ready       response handshake; m_result, m_flags payload
//   busy                  high whenever the FSM is not idle
//   err_drop              one-cycle pulse when an errored result is dropped
//
// Build option: define ALU_SEQ_ERR_DROP_EN to discard errored results
// (no response, err_drop pulse) instead of presenting them.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic                        clk,
   input  logic                        rstN,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [OPERAND_WIDTH-1:0]    s_opcode,
   input  logic [OPERAND_WIDTH-1:0]    s_opA,
   input  logic [OPERAND_WIDTH-1:0]    s_opB,
   output logic                        alu_writeEn,
   output logic [INST_ADDR_LENGTH-1:0] alu_writeAddress,
   output logic [OPERAND_WIDTH-1:0]    alu_inst,
   input  logic [OPERAND_WIDTH-1:0]    alu_result,
   input  logic                        alu_error,
   input  logic                        alu_zero,
   input  logic                        alu_carry,
   input  logic                        alu_overflow,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [OPERAND_WIDTH-1:0]    m_result,
   output logic [3:0]                  m_flags,
   output logic                        busy,
   output logic                        err_drop
);

   seq_state_e               state_q, state_d;
   seq_pkt_t                 pkt_q, pkt_d;
   logic [OPERAND_WIDTH-1:0] res_q, res_d;
   logic [3:0]               flags_q, flags_d;
   logic                     capture;
   logic                     drop_on_err;

`ifdef ALU_SEQ_ERR_DROP_EN
   logic drop_q, drop_d;
   assign drop_on_err = alu_error;
   assign err_drop    = drop_q;
`else
   assign drop_on_err = 1'b0;
   assign err_drop    = 1'b0;
`endif

   // Result is sampled on the edge leaving SETTLE (non-MULT) or
   // leaving MSETTLE (MULT, after the ALU product register updates).
   assign capture =
      (state_q == ST_SETTLE && !needs_mult_settle(pkt_q.op)) ||
      (state_q == ST_MSETTLE);

   // ---------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= ST_IDLE;
         pkt_q   <= '0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

`ifdef ALU_SEQ_ERR_DROP_EN
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= drop_d;
      end
   end

   always_comb begin
      drop_d = capture && drop_on_err;
   end
`endif

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               state_d = ST_WR_A;
            end
         end
         ST_WR_A:  state_d = ST_WR_B;
         ST_WR_B:  state_d = ST_WR_OP;
         ST_WR_OP: state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (needs_mult_settle(pkt_q.op)) begin
               state_d = ST_MSETTLE;
            end else if (drop_on_err) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         ST_MSETTLE: begin
            if (drop_on_err) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (m_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Packet latch and result capture
   always_comb begin
      pkt_d   = pkt_q;
      res_d   = res_q;
      flags_d = flags_q;
      if (state_q == ST_IDLE && s_valid) begin
         pkt_d.op = s_opcode;
         pkt_d.a  = s_opA;
         pkt_d.b  = s_opB;
      end
      if (capture) begin
         res_d   = alu_result;
         flags_d = {alu_error, alu_zero, alu_carry, alu_overflow};
      end
   end

   // ---------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------
   always_comb begin
      alu_writeEn      = 1'b0;
      alu_writeAddress = '0;
      alu_inst         = '0;
      s_ready          = 1'b0;
      m_valid          = 1'b0;
      busy             = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            s_ready = 1'b1;
            busy    = 1'b0;
         end
         ST_WR_A: begin
            alu_writeEn      = 1'b1;
            alu_writeAddress = ALU_ADDR_A;
            alu_inst         = pkt_q.a;
         end
         ST_WR_B: begin
            alu_writeEn      = 1'b1;
            alu_writeAddress = ALU_ADDR_B;
            alu_inst         = pkt_q.b;
         end
         // Opcode goes last so the ALU never sees a new
         // opcode paired with stale operands.
         ST_WR_OP: begin
            alu_writeEn      = 1'b1;
            alu_writeAddress = ALU_ADDR_OP;
            alu_inst         = pkt_q.op;
         end
         ST_OUT: begin
            m_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign m_result = res_q;
   assign m_flags  = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model
// (combinational add/sub/div, registered multiply product).
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rstN;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_opcode, s_opA, s_opB;
   logic        alu_writeEn;
   logic [1:0]  alu_writeAddress;
   logic [15:0] alu_inst;
   logic [15:0] alu_result;
   logic        alu_error, alu_zero, alu_carry, alu_overflow;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_result;
   logic [3:0]  m_flags;
   logic        busy;
   logic        err_drop;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rstN(rstN),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_opcode(s_opcode), .s_opA(s_opA), .s_opB(s_opB),
      .alu_writeEn(alu_writeEn),
      .alu_writeAddress(alu_writeAddress),
      .alu_inst(alu_inst),
      .alu_result(alu_result),
      .alu_error(alu_error), .alu_zero(alu_zero),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_result(m_result), .m_flags(m_flags),
      .busy(busy), .err_drop(err_drop)
   );

   // ---------------- ALU model ----------------
   logic [15:0] r_op = 16'hFFFF;
   logic [15:0] r_a = '0, r_b = '0, prod_q = '0;
   logic [16:0] sum17, diff17;

   always @(posedge clk) begin
      if (alu_writeEn) begin
         case (alu_writeAddress)
            2'd0: r_op <= alu_inst;
            2'd1: r_a  <= alu_inst;
            2'd2: r_b  <= alu_inst;
            default: ;
         endcase
      end
      if (r_op == OP_MULT) prod_q <= r_a * r_b;
   end

   always_comb begin
      sum17 = {1'b0, r_a} + {1'b0, r_b};
      diff17 = {1'b0, r_a} - {1'b0, r_b};
      alu_result = '0;
      alu_error = 1'b0;
      alu_carry = 1'b0;
      alu_overflow = 1'b0;
      case (r_op)
         OP_ADD: begin
            alu_result = sum17[15:0];
            alu_carry = sum17[16];
            alu_overflow = (r_a[15] == r_b[15]) &&
                           (sum17[15] != r_a[15]);
         end
         OP_SUB: begin
            alu_result = diff17[15:0];
            alu_carry = diff17[16];
            alu_overflow = (r_a[15] != r_b[15]) &&
                           (diff17[15] != r_a[15]);
         end
         OP_MULT: alu_result = prod_q;
         OP_DIV: begin
            if (r_b == 16'd0) alu_error = 1'b1;
            else alu_result = r_a / r_b;
         end
         default: alu_error = 1'b1;
      endcase
      alu_zero = !alu_error && (alu_result == 16'd0);
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_pkt(input string nm, input logic [15:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [3:0] ef,
                          input int el, input int hold);
      int lat;
      logic got;
      @(negedge clk);
      chk({nm, "_idle_rdy"}, {30'd0, s_ready, m_valid}, 32'd2);
      s_valid = 1'b1; s_opcode = op; s_opA = a; s_opB = b;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_opcode = 16'h00EE; s_opA = 16'hBEEF; s_opB = 16'h1234;
      chk({nm, "_wr_a"}, {alu_writeEn, alu_writeAddress, alu_inst},
          {13'd0, 1'b1, 2'd1, a});
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1)
            chk({nm, "_wr_b"}, {alu_writeEn, alu_writeAddress, alu_inst},
                {13'd0, 1'b1, 2'd2, b});
         if (lat == 2)
            chk({nm, "_wr_op"}, {alu_writeEn, alu_writeAddress, alu_inst},
                {13'd0, 1'b1, 2'd0, op});
         if (lat == 3)
            chk({nm, "_settle_we"},
                {alu_writeEn, alu_writeAddress, alu_inst}, 32'd0);
         got = m_valid;
      end
      chk({nm, "_latency"}, got ? lat : 99, el);
      if (got) begin
         chk({nm, "_res"}, {12'd0, m_flags, m_result}, {12'd0, ef, er});
         chk({nm, "_busy"}, {busy, s_ready}, 32'd2);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({nm, "_hold"}, {m_valid, s_ready, m_flags, m_result},
             {11'd0, 1'b1, 1'b0, ef, er});
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      chk({nm, "_done"}, {m_valid, s_ready, busy}, 32'd2);
   endtask

   typedef struct {
      string       nm;
      logic [15:0] op, a, b, er;
      logic [3:0]  ef;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nmv, ndrop, lat;
      logic got;
      vecs[0] = '{"add_5_3",   OP_ADD,  16'd5,    16'd3,  16'd8,    4'b0000, 4};
      vecs[1] = '{"add_carry", OP_ADD,  16'hFFFF, 16'd1,  16'd0,    4'b0110, 4};
      vecs[2] = '{"add_ovf",   OP_ADD,  16'h7FFF, 16'd1,  16'h8000, 4'b0001, 4};
      vecs[3] = '{"sub_brw",   OP_SUB,  16'd2,    16'd5,  16'hFFFD, 4'b0010, 4};
      vecs[4] = '{"sub_ovf",   OP_SUB,  16'h8000, 16'd1,  16'h7FFF, 4'b0001, 4};
      vecs[5] = '{"mul_10_3",  OP_MULT, 16'h0010, 16'd3,  16'h0030, 4'b0000, 5};
      vecs[6] = '{"mul_wrap",  OP_MULT, 16'h0100, 16'h100, 16'd0,   4'b0100, 5};
      vecs[7] = '{"div_20_6",  OP_DIV,  16'd20,   16'd6,  16'd3,    4'b0000, 4};
      vecs[8] = '{"add_0_0",   OP_ADD,  16'd0,    16'd0,  16'd0,    4'b0100, 4};

      rstN = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      s_opcode = '0; s_opA = '0; s_opB = '0;
      #23;
      chk("reset_state",
          {s_ready, m_valid, busy, err_drop, alu_writeEn, m_flags, m_result},
          {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0});
      @(negedge clk);
      rstN = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vecs[i])
         run_pkt(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].er, vecs[i].ef, vecs[i].lat, 0);

      // result held while consumer stalls
      run_pkt("sub_stall", OP_SUB, 16'd3, 16'd3, 16'd0, 4'b0100, 4, 10);

`ifndef ALU_SEQ_ERR_DROP_EN
      run_pkt("div_zero", OP_DIV, 16'd7, 16'd0, 16'd0, 4'b1000, 4, 0);
      run_pkt("bad_op", 16'd9, 16'd4, 16'd4, 16'd0, 4'b1000, 4, 0);
      chk("no_err_drop", {31'd0, err_drop}, 32'd0);
`else
      // errored result discarded: no response, single drop pulse
      @(negedge clk);
      s_valid = 1'b1; s_opcode = OP_DIV; s_opA = 16'd7; s_opB = 16'd0;
      @(posedge clk); #1;
      s_valid = 1'b0;
      nmv = 0; ndrop = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         nmv += int'(m_valid);
         ndrop += int'(err_drop);
      end
      chk("div_zero_no_mvalid", nmv, 0);
      chk("div_zero_drop_pulse", ndrop, 1);
      chk("div_zero_idle", {s_ready, busy}, 32'd2);
`endif

      // reset during WR_B aborts the packet
      @(negedge clk);
      s_valid = 1'b1; s_opcode = OP_ADD; s_opA = 16'd50; s_opB = 16'd60;
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_wr_b", {alu_writeEn, alu_writeAddress}, 32'd6);
      rstN = 1'b0;
      #1;
      chk("rst_abort", {alu_writeEn, s_ready, busy, m_valid}, 32'd4);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk); #1;
      chk("rst_next", {alu_writeEn, s_ready, busy}, 32'd2);
      run_pkt("add_1_1", OP_ADD, 16'd1, 16'd1, 16'd2, 4'b0000, 4, 0);

      // back-to-back with s_valid held high
      @(negedge clk);
      s_valid = 1'b1; s_opcode = OP_ADD; s_opA = 16'd10; s_opB = 16'd20;
      @(posedge clk); #1;
      s_opcode = OP_SUB; s_opA = 16'd9; s_opB = 16'd4;
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         got = m_valid;
      end
      chk("b2b_first", {m_valid, m_result}, {15'd0, 1'b1, 16'd30});
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      chk("b2b_idle", {s_ready, m_valid}, 32'd2);
      @(posedge clk); #1;
      s_valid = 1'b0;
      chk("b2b_accept", {alu_writeEn, alu_writeAddress, alu_inst},
          {13'd0, 1'b1, 2'd1, 16'd9});
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         got = m_valid;
      end
      chk("b2b_second", {m_valid, m_flags, m_result},
          {11'd0, 1'b1, 4'b0000, 16'd5});
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
